// File: rtl/fb_pkg.sv
// Shared constants and state type for the frame-buffer fill engine.
package fb_pkg;

    localparam int unsigned FB_W          = 320;
    localparam int unsigned FB_H          = 240;
    localparam int unsigned FB_ADDR_LIMIT = 65536;
    // Row pitch in pixels; the clip unit's (y<<8)+(y<<6) row base assumes this value.
    localparam int unsigned FB_ROW_STRIDE = 320;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StRun,
        StDone
    } fb_state_e;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational rectangle clip: exclusive end corner, row base, start index, empty flag.
module fb_rect_clip #(
    parameter int unsigned FB_W       = fb_pkg::FB_W,
    parameter int unsigned FB_H       = fb_pkg::FB_H,
    parameter int unsigned ADDR_LIMIT = fb_pkg::FB_ADDR_LIMIT
) (
    input  logic [8:0]  i_x,
    input  logic [7:0]  i_y,
    input  logic [8:0]  i_w,
    input  logic [7:0]  i_h,
    output logic [9:0]  o_xe,
    output logic [9:0]  o_ye,
    output logic [16:0] o_row_base,
    output logic [16:0] o_start,
    output logic        o_empty
);

    logic [9:0] w_xsum;
    logic [9:0] w_ysum;

    assign w_xsum = {1'b0, i_x} + {1'b0, i_w};
    assign w_ysum = {2'b0, i_y} + {2'b0, i_h};

    assign o_xe = (w_xsum > 10'(FB_W)) ? 10'(FB_W) : w_xsum;
    assign o_ye = (w_ysum > 10'(FB_H)) ? 10'(FB_H) : w_ysum;

    // y*320 built from two shifts so no multiplier is inferred.
    assign o_row_base = ({9'd0, i_y} << 8) + ({9'd0, i_y} << 6);
    assign o_start    = o_row_base + {8'd0, i_x};

    assign o_empty = (i_w == 9'd0) || (i_h == 8'd0)
                  || ({1'b0, i_x} >= 10'(FB_W))
                  || ({2'b0, i_y} >= 10'(FB_H))
                  || ({1'b0, o_start} >= 18'(ADDR_LIMIT));

endmodule

// File: rtl/fb_fill_engine.sv
// Rectangle-fill initiator: one clipped pixel write per granted cycle on the frame-buffer port.
module fb_fill_engine
    import fb_pkg::*;
#(
    parameter int unsigned FB_W       = fb_pkg::FB_W,
    parameter int unsigned FB_H       = fb_pkg::FB_H,
    parameter int unsigned ADDR_LIMIT = fb_pkg::FB_ADDR_LIMIT
) (
    input  logic        i_clk_cpu,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [8:0]  i_cmd_x,
    input  logic [7:0]  i_cmd_y,
    input  logic [8:0]  i_cmd_w,
    input  logic [7:0]  i_cmd_h,
    input  logic [11:0] i_cmd_color,
    input  logic        i_abort,
    input  logic        i_bus_gnt,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_mem_write,
    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata
);

    fb_state_e   r_state;
    logic [8:0]  r_x;
    logic [7:0]  r_y;
    logic [8:0]  r_w;
    logic [7:0]  r_h;
    logic [11:0] r_color;
    logic [9:0]  r_xe;
    logic [9:0]  r_ye;
    logic [9:0]  r_cur_x;
    logic [9:0]  r_cur_y;
    logic [16:0] r_row_base;
    logic [16:0] r_idx;
    logic        r_mem_write;
    logic [15:0] r_mem_addr;
    logic [11:0] r_mem_wdata;
    logic        r_done;

    logic [9:0]  w_xe;
    logic [9:0]  w_ye;
    logic [16:0] w_row_base;
    logic [16:0] w_start;
    logic        w_empty;

    fb_rect_clip #(
        .FB_W       (FB_W),
        .FB_H       (FB_H),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_clip (
        .i_x        (r_x),
        .i_y        (r_y),
        .i_w        (r_w),
        .i_h        (r_h),
        .o_xe       (w_xe),
        .o_ye       (w_ye),
        .o_row_base (w_row_base),
        .o_start    (w_start),
        .o_empty    (w_empty)
    );

    logic [9:0]  w_next_x;
    logic        w_row_end;
    logic        w_last_row;
    logic [16:0] w_next_row_base;
    logic [16:0] w_next_idx;
    logic        w_next_over;

    // Cursor successor in row-major order and the address-limit test on it.
    always_comb begin
        w_next_x        = r_cur_x + 10'd1;
        w_row_end       = (w_next_x >= r_xe);
        w_last_row      = ((r_cur_y + 10'd1) >= r_ye);
        w_next_row_base = r_row_base + 17'(FB_ROW_STRIDE);
        w_next_idx      = w_row_end ? (w_next_row_base + {8'd0, r_x}) : (r_idx + 17'd1);
        w_next_over     = ({1'b0, w_next_idx} >= 18'(ADDR_LIMIT));
    end

    // Control FSM with registered write-port and done outputs.
    always_ff @(posedge i_clk_cpu) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_x         <= '0;
            r_y         <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_color     <= '0;
            r_xe        <= '0;
            r_ye        <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_row_base  <= '0;
            r_idx       <= '0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
        end else begin
            r_mem_write <= 1'b0;
            r_done      <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_x     <= i_cmd_x;
                        r_y     <= i_cmd_y;
                        r_w     <= i_cmd_w;
                        r_h     <= i_cmd_h;
                        r_color <= i_cmd_color;
                        r_state <= StSetup;
                    end
                end
                StSetup: begin
                    r_xe       <= w_xe;
                    r_ye       <= w_ye;
                    r_row_base <= w_row_base;
                    r_idx      <= w_start;
                    r_cur_x    <= {1'b0, r_x};
                    r_cur_y    <= {2'b0, r_y};
                    r_state    <= w_empty ? StDone : StRun;
                end
                StRun: begin
                    // Abort wins over a simultaneous grant: no write on this edge.
                    if (i_abort) begin
                        r_state <= StDone;
                    end else if (i_bus_gnt) begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= r_idx[15:0];
                        r_mem_wdata <= r_color;
                        if ((w_row_end && w_last_row) || w_next_over) begin
                            r_state <= StDone;
                        end else begin
                            if (w_row_end) begin
                                r_cur_x    <= {1'b0, r_x};
                                r_cur_y    <= r_cur_y + 10'd1;
                                r_row_base <= w_next_row_base;
                            end else begin
                                r_cur_x <= w_next_x;
                            end
                            r_idx <= w_next_idx;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_cmd_ready = (r_state == StIdle);
    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
    assign o_mem_write = r_mem_write;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = {20'd0, r_mem_wdata};

endmodule

// File: tb/tb_fb_fill_engine.sv
// Self-checking bench for fb_fill_engine: directed fills plus randomized traffic vs a pixel-list model.
module tb_fb_fill_engine;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [8:0]  i_cmd_x;
    logic [7:0]  i_cmd_y;
    logic [8:0]  i_cmd_w;
    logic [7:0]  i_cmd_h;
    logic [11:0] i_cmd_color;
    logic        i_abort;
    logic        i_bus_gnt;
    logic        o_busy;
    logic        o_done;
    logic        o_mem_write;
    logic [15:0] o_mem_addr;
    logic [31:0] o_mem_wdata;

    fb_fill_engine u_dut (
        .i_clk_cpu   (clk),
        .i_reset     (i_reset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_x     (i_cmd_x),
        .i_cmd_y     (i_cmd_y),
        .i_cmd_w     (i_cmd_w),
        .i_cmd_h     (i_cmd_h),
        .i_cmd_color (i_cmd_color),
        .i_abort     (i_abort),
        .i_bus_gnt   (i_bus_gnt),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mem_write (o_mem_write),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cyc = -1;
    int obs_addr[$];
    int obs_cyc[$];
    logic chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Number of pixels a command writes: clipped rectangle, stopping at the first unreachable index.
    function automatic int count_pix(input int x, input int y, input int w, input int h);
        int xe, ye, n;
        n  = 0;
        xe = (x + w < 320) ? x + w : 320;
        ye = (y + h < 240) ? y + h : 240;
        for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
                if (r * 320 + c < 65536) n++;
        return n;
    endfunction

    // Linear index of the k-th pixel in row-major order of the clipped rectangle.
    function automatic int pix_addr(input int x, input int y, input int w, input int k);
        int cw;
        cw = ((x + w < 320) ? x + w : 320) - x;
        return (y + k / cw) * 320 + x + k % cw;
    endfunction

    // Reference model: expected outputs after each clock edge.
    int          m_phase = 0;  // 0 idle, 1 setup, 2 run, 3 done
    int          m_x = 0, m_y = 0, m_w = 0, m_n = 0, m_k = 0;
    logic [11:0] m_col = '0;
    logic        m_write = 1'b0;
    logic        m_done = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_wdata = '0;

    always @(posedge clk) begin
        m_write <= 1'b0;
        m_done  <= 1'b0;
        if (i_reset) begin
            m_phase <= 0;
            m_addr  <= 0;
            m_wdata <= '0;
        end else begin
            case (m_phase)
                0: if (i_cmd_valid) begin
                    m_x     <= int'(i_cmd_x);
                    m_y     <= int'(i_cmd_y);
                    m_w     <= int'(i_cmd_w);
                    m_col   <= i_cmd_color;
                    m_n     <= count_pix(int'(i_cmd_x), int'(i_cmd_y), int'(i_cmd_w), int'(i_cmd_h));
                    m_k     <= 0;
                    m_phase <= 1;
                end
                1: m_phase <= (m_n == 0) ? 3 : 2;
                2: if (i_abort) begin
                    m_phase <= 3;
                end else if (i_bus_gnt) begin
                    m_write <= 1'b1;
                    m_addr  <= pix_addr(m_x, m_y, m_w, m_k);
                    m_wdata <= {20'd0, m_col};
                    m_k     <= m_k + 1;
                    if (m_k + 1 == m_n) m_phase <= 3;
                end
                default: begin
                    m_done  <= 1'b1;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process plus write/done log for the directed checks.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_write", longint'(o_mem_write), longint'(m_write));
            check("done", longint'(o_done), longint'(m_done));
            check("busy", longint'(o_busy), longint'(m_phase != 0));
            check("cmd_ready", longint'(o_cmd_ready), longint'(m_phase == 0));
            check("mem_addr", longint'(o_mem_addr), longint'(m_addr));
            check("mem_wdata", longint'(o_mem_wdata), longint'(m_wdata));
        end
        if (o_mem_write === 1'b1) begin
            obs_addr.push_back(int'(o_mem_addr));
            obs_cyc.push_back(cyc - t0);
        end
        if (o_done === 1'b1) done_cyc <= cyc - t0;
    end

    // Issue one command from idle; gap=1 gives grant pattern 1,0,0,1,... from the first RUN edge.
    task automatic fill(input int x, input int y, input int w, input int h, input int col,
                        input int gap, input int abort_at);
        obs_addr.delete();
        obs_cyc.delete();
        done_cyc    = -1;
        i_cmd_x     = 9'(x);
        i_cmd_y     = 8'(y);
        i_cmd_w     = 9'(w);
        i_cmd_h     = 8'(h);
        i_cmd_color = 12'(col);
        i_cmd_valid = 1'b1;
        i_bus_gnt   = 1'b1;
        i_abort     = 1'b0;
        t0          = cyc + 1;
        for (int c = 1; c < 80; c++) begin
            @(negedge clk);
            #1;
            i_cmd_valid = 1'b0;
            if (done_cyc >= 0) break;
            i_bus_gnt = (gap == 0) ? 1'b1 : ((c - 2) % 3 == 0);
            i_abort   = (c == abort_at);
        end
        i_abort   = 1'b0;
        i_bus_gnt = 1'b0;
        check("fill_timeout", longint'(done_cyc >= 0), 1);
    endtask

    initial begin
        int basic_a[6];
        int gap_c[4];
        int nw;
        basic_a = '{322, 323, 324, 642, 643, 644};
        gap_c   = '{2, 5, 8, 11};

        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_x = '0; i_cmd_y = '0; i_cmd_w = '0;
        i_cmd_h = '0; i_cmd_color = '0; i_abort = 1'b0; i_bus_gnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_mem_write", longint'(o_mem_write), 0);
        check("rst_mem_addr", longint'(o_mem_addr), 0);
        check("rst_mem_wdata", longint'(o_mem_wdata), 0);
        check("rst_done", longint'(o_done), 0);
        check("rst_busy", longint'(o_busy), 0);
        check("rst_cmd_ready", longint'(o_cmd_ready), 1);
        chk_en  = 1'b1;
        i_reset = 1'b0;

        // Hand-computed anchors for the model itself.
        check("model_count_basic", count_pix(2, 1, 3, 2), 6);
        check("model_count_limit", count_pix(250, 204, 10, 2), 6);
        check("model_addr_basic3", pix_addr(2, 1, 3, 3), 642);
        check("model_count_clip", count_pix(318, 0, 5, 1), 2);

        // Basic fill.
        fill(2, 1, 3, 2, 'hF00, 0, 0);
        check("basic_nwrites", obs_addr.size(), 6);
        for (int i = 0; i < 6 && i < obs_addr.size(); i++) begin
            check("basic_addr", obs_addr[i], basic_a[i]);
            check("basic_cycle", obs_cyc[i], 2 + i);
        end
        check("basic_done_cycle", done_cyc, 8);
        check("basic_wdata", longint'(o_mem_wdata), 32'h0000_0F00);

        // Right/bottom clip.
        fill(318, 0, 5, 1, 'h0A5, 0, 0);
        check("clip_nwrites", obs_addr.size(), 2);
        if (obs_addr.size() == 2) begin
            check("clip_addr0", obs_addr[0], 318);
            check("clip_addr1", obs_addr[1], 319);
        end
        check("clip_done_cycle", done_cyc, 4);

        // Address limit.
        fill(250, 204, 10, 2, 'h123, 0, 0);
        check("limit_nwrites", obs_addr.size(), 6);
        if (obs_addr.size() == 6) begin
            check("limit_first", obs_addr[0], 65530);
            check("limit_last", obs_addr[5], 65535);
        end
        check("limit_done_cycle", done_cyc, 8);

        // Grant gaps on a 4-pixel fill.
        fill(5, 5, 4, 1, 'h0F0, 1, 0);
        check("gap_nwrites", obs_addr.size(), 4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            check("gap_addr", obs_addr[i], 1605 + i);
            check("gap_cycle", obs_cyc[i], gap_c[i]);
        end
        check("gap_done_cycle", done_cyc, 12);

        // Abort with grant at the 3rd pixel of a 10-pixel fill.
        fill(0, 10, 10, 1, 'h00F, 0, 4);
        check("abort_nwrites", obs_addr.size(), 2);
        check("abort_done_cycle", done_cyc, 5);

        // Empty command.
        fill(7, 7, 0, 3, 'hFFF, 0, 0);
        check("empty_nwrites", obs_addr.size(), 0);
        check("empty_done_cycle", done_cyc, 2);

        // Reset in the middle of RUN.
        obs_addr.delete();
        i_cmd_x = 9'd0; i_cmd_y = 8'd20; i_cmd_w = 9'd20; i_cmd_h = 8'd1;
        i_cmd_color = 12'h777; i_cmd_valid = 1'b1; i_bus_gnt = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            i_cmd_valid = 1'b0;
        end
        check("midrst_writing", longint'(o_mem_write), 1);
        i_reset = 1'b1;
        @(negedge clk);
        #1;
        i_reset = 1'b0;
        check("midrst_mem_write", longint'(o_mem_write), 0);
        check("midrst_mem_addr", longint'(o_mem_addr), 0);
        check("midrst_mem_wdata", longint'(o_mem_wdata), 0);
        check("midrst_done", longint'(o_done), 0);
        check("midrst_cmd_ready", longint'(o_cmd_ready), 1);
        nw = obs_addr.size();
        repeat (3) @(negedge clk);
        #1;
        check("midrst_no_more_writes", obs_addr.size(), nw);
        i_bus_gnt = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            i_reset     = ($urandom_range(0, 299) == 0);
            i_cmd_valid = ($urandom_range(0, 1) == 1);
            i_cmd_x     = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(300, 511))
                                                      : 9'($urandom_range(0, 330));
            i_cmd_y     = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(200, 255))
                                                      : 8'($urandom_range(0, 239));
            i_cmd_w     = 9'($urandom_range(0, 24));
            i_cmd_h     = 8'($urandom_range(0, 6));
            i_cmd_color = 12'($urandom);
            i_bus_gnt   = ($urandom_range(0, 3) != 0);
            i_abort     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            #1;
        end

        // Drain any command still in flight, bounded.
        i_reset = 1'b0; i_cmd_valid = 1'b0; i_abort = 1'b0; i_bus_gnt = 1'b1;
        for (int i = 0; i < 400 && o_busy; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_idle", longint'(o_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
